dmem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port data SRAM (D-memory) of the RISC-V test system. It shares the SRAM between the core's D-memory port and a debug/loader port used by the bench or a host to preload and inspect memory. Core has fixed priority, with a starvation guard and a lock mode for debug bursts. The block sits between the core's D-memory signals and the SRAM instance, and stalls the core when it loses the slot.

---
 rtl/dmem_port_arbiter_if.sv | 58 +++++
 rtl/dmem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the three sides of the D-memory arbiter into one interface:
//   c_*   : core D-memory port (active-low csn/wen, byte enables, stall back)
//   dbg_* : debug/loader port (active-high req/we, lock, grant, read valid)
//   m_*   : single-port SRAM request and read data
// Modports:
//   slave  : the arbiter (takes core/debug requests and SRAM read data,
//            drives grants, stall, read data and the SRAM request)
//   master : the environment (core, debug host and SRAM model)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int AWIDTH = 12
);
    // core side
    logic              c_csn;
    logic              c_wen;
    logic [3:0]        c_be;
    logic [AWIDTH-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [31:0]       c_rdata;
    logic              c_stall;
    // debug side
    logic              dbg_req;
    logic              dbg_we;
    logic [3:0]        dbg_be;
    logic [AWIDTH-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic [31:0]       dbg_rdata;
    logic              dbg_rvalid;
    // SRAM side
    logic              m_csn;
    logic              m_wen;
    logic [3:0]        m_be;
    logic [AWIDTH-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  c_csn, c_wen, c_be, c_addr, c_wdata,
        output c_rdata, c_stall,
        input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output m_csn, m_wen, m_be, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_csn, c_wen, c_be, c_addr, c_wdata,
        input  c_rdata, c_stall,
        output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  m_csn, m_wen, m_be, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port D-memory SRAM between the core and a debug/loader
// port. The core has fixed priority; a debug requester denied MAX_WAIT
// consecutive cycles is forced one slot, and DBG_LOCK hands the port to
// debug for whole bursts. Grants, stall and the SRAM request are
// combinational; read data is routed back one cycle after issue.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : core / debug / SRAM signals (slave modport)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {CORE_PRI, DBG_FORCE, LOCKED} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DBG} owner_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    owner_t            rd_owner_reg, rd_owner_next;
    logic [AWIDTH-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       c_rdata_reg;
    logic [31:0]       dbg_rdata_reg;

    logic              core_gnt;
    logic              dbg_gnt;
    logic              stall;
    logic              m_csn;
    logic              m_wen;
    logic [3:0]        m_be;
    logic [AWIDTH-1:0] m_addr;
    logic [31:0]       m_wdata;

    // Grant / stall / next-state decision
    always_comb begin
        core_gnt      = 1'b0;
        dbg_gnt       = 1'b0;
        stall         = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            CORE_PRI: begin
                core_gnt = ~bus.c_csn;
                dbg_gnt  = bus.dbg_req & bus.c_csn;
                if (!bus.dbg_req || dbg_gnt) begin
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt_reg < MAX_CNT) begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
                // Switch on the denial that brings the count to MAX_WAIT so
                // the forced grant lands on the very next cycle.
                if (bus.dbg_req && !dbg_gnt && wait_cnt_next == MAX_CNT) begin
                    state_next = DBG_FORCE;
                end
            end
            DBG_FORCE: begin
                // Slot belongs to debug even if it has dropped its request;
                // in that case the cycle simply goes unused.
                dbg_gnt       = bus.dbg_req;
                stall         = ~bus.c_csn;
                state_next    = CORE_PRI;
                wait_cnt_next = 4'd0;
            end
            LOCKED: begin
                dbg_gnt = bus.dbg_req;
                stall   = ~bus.c_csn;
                if (!bus.dbg_lock) begin
                    state_next    = CORE_PRI;
                    wait_cnt_next = 4'd0;
                end
            end
            default: begin
                state_next    = CORE_PRI;
                wait_cnt_next = 4'd0;
            end
        endcase
        // Lock wins over everything, including a simultaneous counter expiry.
        if (bus.dbg_lock) begin
            state_next    = LOCKED;
            wait_cnt_next = 4'd0;
        end
        // Outputs must sit at their idle values for as long as reset is held,
        // not just after the first edge.
        if (!rst_n) begin
            core_gnt = 1'b0;
            dbg_gnt  = 1'b0;
            stall    = 1'b0;
        end
    end

    // SRAM request mux and read-owner tracking
    always_comb begin
        m_csn         = 1'b1;
        m_wen         = 1'b1;
        m_be          = 4'b0000;
        m_addr        = addr_reg;
        m_wdata       = wdata_reg;
        rd_owner_next = RD_NONE;
        if (core_gnt) begin
            m_csn   = 1'b0;
            m_wen   = bus.c_wen;
            m_be    = bus.c_be;
            m_addr  = bus.c_addr;
            m_wdata = bus.c_wdata;
            if (bus.c_wen) begin
                rd_owner_next = RD_CORE;
            end
        end else if (dbg_gnt) begin
            m_csn   = 1'b0;
            m_wen   = ~bus.dbg_we;
            m_be    = bus.dbg_be;
            m_addr  = bus.dbg_addr;
            m_wdata = bus.dbg_wdata;
            if (!bus.dbg_we) begin
                rd_owner_next = RD_DBG;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CORE_PRI;
            wait_cnt_reg  <= 4'd0;
            rd_owner_reg  <= RD_NONE;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            c_rdata_reg   <= 32'd0;
            dbg_rdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_owner_reg <= rd_owner_next;
            // Address/data bus parks on the last issued access.
            if (!m_csn) begin
                addr_reg  <= m_addr;
                wdata_reg <= m_wdata;
            end
            if (rd_owner_reg == RD_CORE) begin
                c_rdata_reg <= bus.m_rdata;
            end
            if (rd_owner_reg == RD_DBG) begin
                dbg_rdata_reg <= bus.m_rdata;
            end
        end
    end

    // Read data passes straight through in the return cycle, then is held.
    assign bus.c_rdata    = (rd_owner_reg == RD_CORE) ? bus.m_rdata : c_rdata_reg;
    assign bus.dbg_rdata  = (rd_owner_reg == RD_DBG)  ? bus.m_rdata : dbg_rdata_reg;
    assign bus.dbg_rvalid = (rd_owner_reg == RD_DBG);
    assign bus.c_stall    = stall;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.m_csn      = m_csn;
    assign bus.m_wen      = m_wen;
    assign bus.m_be       = m_be;
    assign bus.m_addr     = m_addr;
    assign bus.m_wdata    = m_wdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter (AWIDTH=12, MAX_WAIT=4). Inputs change
// on the falling edge and outputs are checked 1 time unit later, so every
// check sees the cycle whose rising edge comes next. A behavioural SRAM with
// byte enables and one-cycle read latency sits on the m_* side.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    dmem_port_arbiter_if #(.AWIDTH(12)) bus ();

    dmem_port_arbiter #(.AWIDTH(12), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write with byte enables, registered read
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!bus.m_csn) begin
            if (!bus.m_wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.m_be[i]) begin
                        mem[bus.m_addr[11:2]][8*i +: 8] <= bus.m_wdata[8*i +: 8];
                    end
                end
            end else begin
                bus.m_rdata <= mem[bus.m_addr[11:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string name);
        @(negedge clk);
        $display("[%0t] step %s", $time, name);
    endtask

    task automatic core_drv(input logic csn, input logic wen, input logic [3:0] be,
                            input logic [11:0] addr, input logic [31:0] wdata);
        bus.c_csn   = csn;
        bus.c_wen   = wen;
        bus.c_be    = be;
        bus.c_addr  = addr;
        bus.c_wdata = wdata;
    endtask

    task automatic dbg_drv(input logic req, input logic we, input logic [3:0] be,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           input logic lock);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_be    = be;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
        bus.dbg_lock  = lock;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);

        // ---- outputs while reset is held, with debug requesting ----
        tick("reset_hold");
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
        #1;
        check("rst_dbg_gnt",    32'(bus.dbg_gnt),    32'd0);
        check("rst_m_csn",      32'(bus.m_csn),      32'd1);
        check("rst_m_wen",      32'(bus.m_wen),      32'd1);
        check("rst_m_be",       32'(bus.m_be),       32'd0);
        check("rst_c_stall",    32'(bus.c_stall),    32'd0);
        check("rst_c_rdata",    bus.c_rdata,         32'h0);
        check("rst_dbg_rdata",  bus.dbg_rdata,       32'h0);
        check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        tick("reset_release");
        rst_n = 1'b1;
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("idle_m_csn", 32'(bus.m_csn), 32'd1);

        // ---- core-only traffic ----
        tick("core_write_010");
        core_drv(1'b0, 1'b0, 4'hF, 12'h010, 32'hDEADBEEF);
        #1;
        check("cw_c_stall", 32'(bus.c_stall), 32'd0);
        check("cw_m_csn",   32'(bus.m_csn),   32'd0);
        check("cw_m_wen",   32'(bus.m_wen),   32'd0);
        check("cw_m_wdata", bus.m_wdata,      32'hDEADBEEF);

        tick("core_read_010");
        core_drv(1'b0, 1'b1, 4'hF, 12'h010, 32'h0);
        #1;
        check("cr_c_stall", 32'(bus.c_stall), 32'd0);
        check("cr_m_wen",   32'(bus.m_wen),   32'd1);
        check("cr_m_addr",  32'(bus.m_addr),  32'h010);

        tick("core_read_return");
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        #1;
        check("cr_c_rdata",   bus.c_rdata,       32'hDEADBEEF);
        check("cr2_c_stall",  32'(bus.c_stall),  32'd0);
        check("idle_m_csn2",  32'(bus.m_csn),    32'd1);
        check("idle_m_addr",  32'(bus.m_addr),   32'h010);

        // ---- debug-only traffic ----
        tick("dbg_write_020");
        dbg_drv(1'b1, 1'b1, 4'hF, 12'h020, 32'h00000EEC, 1'b0);
        #1;
        check("dw_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("dw_m_wen",   32'(bus.m_wen),   32'd0);
        check("dw_m_addr",  32'(bus.m_addr),  32'h020);

        tick("dbg_read_020");
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
        #1;
        check("dr_dbg_gnt",    32'(bus.dbg_gnt),    32'd1);
        check("dr_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("dr_m_wen",      32'(bus.m_wen),      32'd1);

        tick("dbg_read_return");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("dr_rvalid",  32'(bus.dbg_rvalid), 32'd1);
        check("dr_rdata",   bus.dbg_rdata,       32'h00000EEC);
        check("dr_gnt_off", 32'(bus.dbg_gnt),    32'd0);

        tick("idle");
        #1;
        check("dr_rvalid_off", 32'(bus.dbg_rvalid), 32'd0);

        // ---- starvation: core reads every cycle, debug reads 0x020 ----
        for (int k = 1; k <= 4; k++) begin
            tick($sformatf("starve_deny_%0d", k));
            core_drv(1'b0, 1'b1, 4'hF, 12'h010, 32'h0);
            dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
            #1;
            check($sformatf("sv_dbg_gnt_%0d", k), 32'(bus.dbg_gnt), 32'd0);
            check($sformatf("sv_c_stall_%0d", k), 32'(bus.c_stall), 32'd0);
        end
        tick("starve_forced");
        #1;
        check("sv_force_gnt",   32'(bus.dbg_gnt), 32'd1);
        check("sv_force_stall", 32'(bus.c_stall), 32'd1);
        check("sv_force_addr",  32'(bus.m_addr),  32'h020);
        check("sv_force_crd",   bus.c_rdata,      32'hDEADBEEF);

        tick("starve_core_retry");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("sv_retry_stall",  32'(bus.c_stall),    32'd0);
        check("sv_retry_csn",    32'(bus.m_csn),      32'd0);
        check("sv_retry_addr",   32'(bus.m_addr),     32'h010);
        check("sv_retry_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check("sv_retry_rdata",  bus.dbg_rdata,       32'h00000EEC);
        check("sv_retry_crd",    bus.c_rdata,         32'hDEADBEEF);

        tick("starve_idle");
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        #1;
        check("sv_idle_crd",    bus.c_rdata,         32'hDEADBEEF);
        check("sv_idle_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        // ---- forced slot but debug drops its request ----
        for (int k = 1; k <= 4; k++) begin
            tick($sformatf("drop_deny_%0d", k));
            core_drv(1'b0, 1'b1, 4'hF, 12'h010, 32'h0);
            dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
            #1;
            check($sformatf("dp_dbg_gnt_%0d", k), 32'(bus.dbg_gnt), 32'd0);
        end
        tick("drop_forced_slot");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("dp_m_csn",   32'(bus.m_csn),   32'd1);
        check("dp_c_stall", 32'(bus.c_stall), 32'd1);
        check("dp_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);

        tick("drop_core_resume");
        #1;
        check("dp_resume_stall", 32'(bus.c_stall), 32'd0);
        check("dp_resume_csn",   32'(bus.m_csn),   32'd0);

        // ---- lock burst ----
        tick("lock_assert");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1);
        #1;
        check("lk0_c_stall", 32'(bus.c_stall), 32'd0);
        check("lk0_m_addr",  32'(bus.m_addr),  32'h010);

        tick("lock_write_100");
        dbg_drv(1'b1, 1'b1, 4'hF, 12'h100, 32'h11111111, 1'b1);
        #1;
        check("lk1_c_stall", 32'(bus.c_stall), 32'd1);
        check("lk1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("lk1_m_addr",  32'(bus.m_addr),  32'h100);

        tick("lock_write_104");
        dbg_drv(1'b1, 1'b1, 4'hF, 12'h104, 32'h22222222, 1'b1);
        #1;
        check("lk2_c_stall", 32'(bus.c_stall), 32'd1);
        check("lk2_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);

        tick("lock_write_108_release");
        dbg_drv(1'b1, 1'b1, 4'hF, 12'h108, 32'h33333333, 1'b0);
        #1;
        check("lk3_c_stall", 32'(bus.c_stall), 32'd1);
        check("lk3_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("lk3_m_addr",  32'(bus.m_addr),  32'h108);

        tick("lock_core_resume");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("lk4_c_stall", 32'(bus.c_stall), 32'd0);
        check("lk4_m_csn",   32'(bus.m_csn),   32'd0);
        check("lk4_m_addr",  32'(bus.m_addr),  32'h010);

        tick("lock_readback_104");
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h104, 32'h0, 1'b0);
        #1;
        check("lk5_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);

        tick("lock_readback_return");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("lk6_dbg_rdata", bus.dbg_rdata, 32'h22222222);
        check("lk6_c_rdata",   bus.c_rdata,   32'hDEADBEEF);

        // ---- byte enables ----
        tick("be_dbg_write_ones");
        dbg_drv(1'b1, 1'b1, 4'hF, 12'h040, 32'hFFFFFFFF, 1'b0);
        #1;
        check("be1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);

        tick("be_core_write_byte0");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        core_drv(1'b0, 1'b0, 4'b0001, 12'h040, 32'h000000AB);
        #1;
        check("be2_c_stall", 32'(bus.c_stall), 32'd0);
        check("be2_m_be",    32'(bus.m_be),    32'h1);

        tick("be_dbg_read");
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b0);
        #1;
        check("be3_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);

        tick("be_read_return");
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("be4_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check("be4_rdata",  bus.dbg_rdata,       32'hFFFFFFAB);

        // ---- reset during a debug read (lock also raised) ----
        tick("rr_dbg_read_lock");
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b1);
        #1;
        check("rr1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);

        tick("rr_reset_assert");
        rst_n = 1'b0;
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        core_drv(1'b0, 1'b1, 4'hF, 12'h010, 32'h0);
        #1;
        check("rr2_rvalid",  32'(bus.dbg_rvalid), 32'd0);
        check("rr2_m_csn",   32'(bus.m_csn),      32'd1);
        check("rr2_dbg_rd",  bus.dbg_rdata,       32'h0);
        check("rr2_c_rdata", bus.c_rdata,         32'h0);
        check("rr2_c_stall", 32'(bus.c_stall),    32'd0);

        tick("rr_reset_release");
        rst_n = 1'b1;
        dbg_drv(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
        #1;
        check("rr3_c_stall", 32'(bus.c_stall), 32'd0);
        check("rr3_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        check("rr3_m_addr",  32'(bus.m_addr),  32'h010);

        tick("rr_core_return");
        core_drv(1'b1, 1'b1, 4'h0, 12'h000, 32'h0);
        dbg_drv(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0);
        #1;
        check("rr4_c_rdata", bus.c_rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
